// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, data word, and the RAM arbiter FSM state.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of back-to-back data grants taken while a fetch waits; flags when the limit is hit.
module arb_streak_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic starve_c
);

  localparam int unsigned CNT_W = (LIMIT > 7) ? $clog2(LIMIT + 1) : 3;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign starve_c = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the unified single-ported RAM between instruction fetch and the MEM-stage data port.
// Optional fetch starvation guard: define ARB_FAIR_EN.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("ram_arbiter: STARVE_LIMIT must be at least 1");
  end

  arb_state_t state_q, state_d;
  logic       dreq_c;
  logic       icpl_c;
  logic       dcpl_c;
  logic       starve_c;

  assign dreq_c = dREN | dWEN;
  assign icpl_c = (state_q == IGNT) && (ramstate == ACCESS) && iREN;
  assign dcpl_c = (state_q == DGNT) && (ramstate == ACCESS) && dreq_c;

`ifdef ARB_FAIR_EN
  arb_streak_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_streak (
    .clk     (CLK),
    .rst_n   (nRST),
    .inc     (dcpl_c & iREN),
    .clr     (icpl_c | ~iREN),
    .starve_c(starve_c)
  );
`else
  assign starve_c = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant selection plus RAM drive; strobes follow the live request so a withdrawn request aborts at once.
  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IDLE: begin
        if (iREN && starve_c) begin
          state_d = IGNT;
        end else if (dreq_c) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN || (ramstate == ACCESS) || (ramstate == ERROR)) begin
          state_d = IDLE;
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!dreq_c || (ramstate == ACCESS) || (ramstate == ERROR)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign iwait = iREN & ~icpl_c;
  assign dwait = dreq_c & ~dcpl_c;
  assign iload = icpl_c ? ramload : '0;
  assign dload = dcpl_c ? ramload : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, fetch, contention, abort, error retry, async reset, fairness.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              nRST;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;

  int vec_cnt = 0;
  int err_cnt = 0;

  ram_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  initial begin
    int  ncpl;
    int  dstreak;
    bit  got_i;
    bit  exp_i;

    nRST     = 1'b0;
    iREN     = 1'b1;
    iaddr    = 32'h40;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramstate = FREE;

    // Reset held with a pending fetch
    sample();
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_iwait", iwait, 1);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    #1 nRST = 1'b1;

    // Lone fetch: two BUSY cycles then ACCESS
    tick();
    ramstate = BUSY;
    sample();
    check("f_ramREN", ramREN, 1);
    check("f_ramaddr", ramaddr, 32'h40);
    check("f_busy1_iwait", iwait, 1);
    tick();
    sample();
    check("f_busy2_iwait", iwait, 1);
    check("f_busy2_iload", iload, 0);
    tick();
    ramstate = ACCESS;
    ramload  = 32'h8C220004;
    sample();
    check("f_cpl_iwait", iwait, 0);
    check("f_cpl_iload", iload, 32'h8C220004);
    tick();
    iREN     = 1'b0;
    ramstate = FREE;
    ramload  = '0;
    sample();
    check("f_idle_ramREN", ramREN, 0);
    check("f_idle_ramaddr", ramaddr, 0);

    // Contention: write wins, fetch follows after a bubble
    tick();
    iREN   = 1'b1;
    dWEN   = 1'b1;
    daddr  = 32'h100;
    dstore = 32'hDEAD;
    sample();
    check("c_idle_ramWEN", ramWEN, 0);
    check("c_idle_dwait", dwait, 1);
    check("c_idle_iwait", iwait, 1);
    tick();
    ramstate = BUSY;
    sample();
    check("c_dgnt_ramWEN", ramWEN, 1);
    check("c_dgnt_ramREN", ramREN, 0);
    check("c_dgnt_ramaddr", ramaddr, 32'h100);
    check("c_dgnt_ramstore", ramstore, 32'hDEAD);
    check("c_dgnt_iwait", iwait, 1);
    tick();
    ramstate = ACCESS;
    sample();
    check("c_dcpl_dwait", dwait, 0);
    check("c_dcpl_iwait", iwait, 1);
    tick();
    dWEN     = 1'b0;
    ramstate = FREE;
    sample();
    check("c_bubble_ramREN", ramREN, 0);
    check("c_bubble_ramWEN", ramWEN, 0);
    check("c_bubble_iwait", iwait, 1);
    tick();
    ramstate = BUSY;
    sample();
    check("c_ignt_ramREN", ramREN, 1);
    check("c_ignt_ramaddr", ramaddr, 32'h40);

    // Flush abort while BUSY
    tick();
    iREN = 1'b0;
    sample();
    check("a_ramREN", ramREN, 0);
    check("a_iload", iload, 0);
    tick();
    iREN = 1'b1;
    sample();
    check("a_idle_ramREN", ramREN, 0);
    check("a_idle_iwait", iwait, 1);
    tick();
    ramstate = ACCESS;
    ramload  = 32'h1234;
    sample();
    check("a_refetch_iwait", iwait, 0);
    check("a_refetch_iload", iload, 32'h1234);

    // ERROR during a data read retries after an IDLE bubble
    tick();
    iREN     = 1'b0;
    ramstate = FREE;
    ramload  = '0;
    dREN     = 1'b1;
    daddr    = 32'h200;
    sample();
    check("e_idle_ramREN", ramREN, 0);
    check("e_idle_dwait", dwait, 1);
    tick();
    ramstate = ERROR;
    sample();
    check("e_err_ramREN", ramREN, 1);
    check("e_err_ramaddr", ramaddr, 32'h200);
    check("e_err_dwait", dwait, 1);
    check("e_err_dload", dload, 0);
    tick();
    ramstate = FREE;
    sample();
    check("e_bubble_ramREN", ramREN, 0);
    check("e_bubble_dwait", dwait, 1);
    tick();
    ramstate = ACCESS;
    ramload  = 32'hCAFE;
    sample();
    check("e_retry_ramREN", ramREN, 1);
    check("e_retry_dwait", dwait, 0);
    check("e_retry_dload", dload, 32'hCAFE);

    // Asynchronous reset in the middle of a write
    tick();
    dREN     = 1'b0;
    dWEN     = 1'b1;
    daddr    = 32'h300;
    ramstate = FREE;
    ramload  = '0;
    tick();
    ramstate = BUSY;
    sample();
    check("r_ramWEN_before", ramWEN, 1);
    #1 nRST = 1'b0;
    #1;
    check("r_ramWEN_async", ramWEN, 0);
    check("r_ramaddr_async", ramaddr, 0);
    dWEN = 1'b0;
    tick();
    nRST     = 1'b1;
    ramstate = FREE;
    sample();
    check("r_after_ramWEN", ramWEN, 0);

    // Continuous data and fetch demand with an always-ready RAM
    tick();
    dREN     = 1'b1;
    iREN     = 1'b1;
    daddr    = 32'h400;
    iaddr    = 32'h80;
    ramstate = ACCESS;
    ramload  = 32'h55;
    ncpl     = 0;
    dstreak  = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      sample();
      if (!dwait || !iwait) begin
        got_i = !iwait;
        exp_i = FAIR && (dstreak == int'(STARVE_LIMIT));
        check($sformatf("fair_kind_%0d", ncpl), got_i, exp_i);
        if (got_i) check($sformatf("fair_iload_%0d", ncpl), iload, 32'h55);
        else       check($sformatf("fair_dload_%0d", ncpl), dload, 32'h55);
        dstreak = exp_i ? 0 : dstreak + 1;
        ncpl++;
      end
      tick();
    end
    check("fair_cpl_count", 32'(ncpl), 20);
    dREN     = 1'b0;
    iREN     = 1'b0;
    ramstate = FREE;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
